// File: rtl/uart_pkg.sv
// Shared constants for the UART MMIO controller: register offsets, status
// bit positions and the transmit sequencer state encoding.
package uart_pkg;

  localparam logic [2:0] ADDR_DATA = 3'h0;
  localparam logic [2:0] ADDR_STAT = 3'h4;

  localparam int STAT_TXRDY = 0;
  localparam int STAT_RXAV  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FULL  = 3;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_WAIT_BUSY,
    T_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with a combinational head view. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [7:0]       i_wdata,
  input  logic             i_pop,
  output logic [7:0]       o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A pop frees the slot the push lands in, so a full FIFO still accepts
  // a push that coincides with a pop.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing UART controller: DATA/STAT register window, RX completion edge
// capture into a FIFO, and a one-byte TX holding register with start/busy FSM.
module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_ce,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        read_ce,
  input  logic        rx_fin,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        irq
);

  logic        r_fin_s1;
  logic        r_fin_s2;
  logic        r_fin_d;
  logic        r_ovr;
  logic        r_irq;
  logic        r_tx_ready;
  logic [7:0]  r_tx_data;
  logic [31:0] r_bus_rdata;
  logic        r_bus_rvalid;
  tx_state_t   r_state;
  tx_state_t   w_state_next;

  logic           w_fin_rise;
  logic           w_rd;
  logic           w_wr;
  logic           w_is_stat;
  logic           w_pop;
  logic           w_hold_load;
  logic           w_ovr_set;
  logic           w_tx_start;
  logic [31:0]    w_stat;
  logic [7:0]     w_fifo_head;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [PTR_W:0] w_fifo_count;

  // Only the STAT offset bit selects the register; the low bits are don't-care.
  assign w_is_stat   = ((bus_addr & ADDR_STAT) != ADDR_DATA);
  assign w_rd        = bus_ce & ~bus_we;
  assign w_wr        = bus_ce & bus_we;
  assign w_pop       = w_rd & ~w_is_stat;
  assign w_hold_load = w_wr & ~w_is_stat & r_tx_ready;
  assign w_fin_rise  = r_fin_s2 & ~r_fin_d;
  assign w_ovr_set   = w_fin_rise & w_fifo_full & ~w_pop;

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fin_rise),
    .i_wdata (rx_data),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_stat             = '0;
    w_stat[STAT_TXRDY] = r_tx_ready;
    w_stat[STAT_RXAV]  = (w_fifo_count != '0);
    w_stat[STAT_OVR]   = r_ovr;
    w_stat[STAT_FULL]  = w_fifo_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin_s1     <= 1'b0;
      r_fin_s2     <= 1'b0;
      r_fin_d      <= 1'b0;
      r_ovr        <= 1'b0;
      r_irq        <= 1'b0;
      r_tx_ready   <= 1'b1;
      r_tx_data    <= '0;
      r_bus_rdata  <= '0;
      r_bus_rvalid <= 1'b0;
    end else begin
      r_fin_s1     <= rx_fin;
      r_fin_s2     <= r_fin_s1;
      r_fin_d      <= r_fin_s2;
      r_bus_rvalid <= w_rd;
      r_irq        <= ~w_fifo_empty | r_ovr;

      if (w_rd) begin
        if (w_is_stat)         r_bus_rdata <= w_stat;
        else if (w_fifo_empty) r_bus_rdata <= '0;
        else                   r_bus_rdata <= {24'h0, w_fifo_head};
      end

      // A new overrun outranks the clear-on-read of the previous one.
      if (w_ovr_set)                r_ovr <= 1'b1;
      else if (w_rd && w_is_stat)   r_ovr <= 1'b0;

      if (w_hold_load) begin
        r_tx_data  <= bus_wdata;
        r_tx_ready <= 1'b0;
      end else if (r_state == T_WAIT_DONE && !tx_busy) begin
        r_tx_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= T_IDLE;
    else     r_state <= w_state_next;
  end

  // Loading the holding register jumps straight to T_START so tx_start
  // follows the bus write by a single cycle.
  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    case (r_state)
      T_IDLE: begin
        if (w_hold_load || !r_tx_ready) w_state_next = T_START;
      end
      T_START: begin
        w_tx_start   = 1'b1;
        w_state_next = T_WAIT_BUSY;
      end
      T_WAIT_BUSY: begin
        if (tx_busy) w_state_next = T_WAIT_DONE;
      end
      T_WAIT_DONE: begin
        if (!tx_busy) w_state_next = T_IDLE;
      end
      default: w_state_next = T_IDLE;
    endcase
  end

  assign read_ce    = ~rst;
  assign tx_start   = w_tx_start;
  assign tx_data    = r_tx_data;
  assign irq        = r_irq;
  assign bus_rdata  = r_bus_rdata;
  assign bus_rvalid = r_bus_rvalid;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed scenario bench for uart_mmio_ctrl; each task drives one scenario
// and compares DUT outputs against hand-computed values.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_ce;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        read_ce;
  logic        rx_fin;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        irq;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [2:0] A_DATA = 3'h0;
  localparam logic [2:0] A_STAT = 3'h4;

  uart_mmio_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_ce     (bus_ce),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .read_ce    (read_ce),
    .rx_fin     (rx_fin),
    .rx_data    (rx_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    bus_ce = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    bus_ce = 1'b0;
    d = bus_rdata;
    v = bus_rvalid;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] b);
    bus_ce = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = b;
    tick();
    bus_ce = 1'b0; bus_we = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b; rx_fin = 1'b1;
    repeat (3) tick();
    rx_fin = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1; bus_ce = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    rx_fin = 0; rx_data = 0; tx_busy = 0;
    repeat (3) tick();
    n_vec++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", bus_rdata, 32'h0); end
    n_vec++; if (bus_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus_rvalid); end
    n_vec++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    n_vec++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_vec++; if (read_ce !== 1'b0) begin n_fail++; $display("FAIL reset_read_ce: got %b expected 0", read_ce); end
    n_vec++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b0;
    tick();
    n_vec++; if (read_ce !== 1'b1) begin n_fail++; $display("FAIL run_read_ce: got %b expected 1", read_ce); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1 || v !== 1'b1) begin n_fail++; $display("FAIL reset_stat: got %h/%b expected 00000001/1", d, v); end
    $display("reset: STAT=%h", d);
  endtask

  task automatic test_rx_single();
    logic [31:0] d; logic v;
    rx_data = 8'hA5; rx_fin = 1'b1;
    tick(); tick();
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL rx_stat_early: got %h expected %h", d, 32'h1); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h3 || v !== 1'b1) begin n_fail++; $display("FAIL rx_stat_avail: got %h/%b expected 00000003/1", d, v); end
    n_vec++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq_set: got %b expected 1", irq); end
    rx_fin = 1'b0;
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'hA5 || v !== 1'b1) begin n_fail++; $display("FAIL rx_data_a5: got %h/%b expected 000000a5/1", d, v); end
    tick();
    n_vec++; if (bus_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_cycle: got %b expected 0", bus_rvalid); end
    n_vec++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL rx_stat_drained: got %h expected %h", d, 32'h1); end
    $display("rx_single: byte a5 pushed and popped, STAT=%h", d);
    repeat (3) tick();
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic v;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'hF) begin n_fail++; $display("FAIL ovr_stat: got %h expected %h", d, 32'hF); end
    n_vec++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_irq: got %b expected 1", irq); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'hB) begin n_fail++; $display("FAIL ovr_cleared: got %h expected %h", d, 32'hB); end
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, d, v);
      n_vec++; if (d !== 32'(i)) begin n_fail++; $display("FAIL ovr_drain[%0d]: got %h expected %h", i, d, 32'(i)); end
    end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL ovr_stat_empty: got %h expected %h", d, 32'h1); end
    $display("overflow: 17 pushed, 16 drained, STAT=%h", d);
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d; logic v;
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'hB) begin n_fail++; $display("FAIL full_stat: got %h expected %h", d, 32'hB); end
    rx_data = 8'h99; rx_fin = 1'b1;
    tick(); tick();
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'h40) begin n_fail++; $display("FAIL full_pp_head: got %h expected %h", d, 32'h40); end
    rx_fin = 1'b0;
    repeat (3) tick();
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'hB) begin n_fail++; $display("FAIL full_pp_stat: got %h expected %h", d, 32'hB); end
    for (int i = 1; i < 16; i++) begin
      bus_read(A_DATA, d, v);
      n_vec++; if (d !== 32'h40 + 32'(i)) begin n_fail++; $display("FAIL full_pp_drain[%0d]: got %h expected %h", i, d, 32'h40 + 32'(i)); end
    end
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'h99) begin n_fail++; $display("FAIL full_pp_tail: got %h expected %h", d, 32'h99); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL full_pp_empty: got %h expected %h", d, 32'h1); end
    $display("full_push_pop: simultaneous push/pop at full, last byte %h", 8'h99);
  endtask

  task automatic test_empty_read();
    logic [31:0] d; logic v;
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'h0 || v !== 1'b1) begin n_fail++; $display("FAIL empty_read: got %h/%b expected 00000000/1", d, v); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL empty_read_stat: got %h expected %h", d, 32'h1); end
    push_byte(8'h5A);
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'h5A) begin n_fail++; $display("FAIL empty_ptr_kept: got %h expected %h", d, 32'h5A); end
    rx_data = 8'hC3; rx_fin = 1'b1;
    tick(); tick();
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_pp_pop: got %h expected %h", d, 32'h0); end
    rx_fin = 1'b0;
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h3) begin n_fail++; $display("FAIL empty_pp_stat: got %h expected %h", d, 32'h3); end
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'hC3) begin n_fail++; $display("FAIL empty_pp_push: got %h expected %h", d, 32'hC3); end
    $display("empty_read: empty pops return 0, pointers intact");
    repeat (3) tick();
  endtask

  task automatic test_tx();
    logic [31:0] d; logic v;
    int pulses;
    bus_write(A_DATA, 8'h3C);
    n_vec++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin n_fail++; $display("FAIL tx_start: got %b/%h expected 1/3c", tx_start, tx_data); end
    tick();
    n_vec++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL tx_start_width: got %b expected 0", tx_start); end
    bus_write(A_DATA, 8'h77);
    tx_busy = 1'b1;
    pulses = 0;
    repeat (9) begin
      tick();
      if (tx_start === 1'b1) pulses++;
    end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h0) begin n_fail++; $display("FAIL tx_busy_stat: got %h expected %h", d, 32'h0); end
    tx_busy = 1'b0;
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h0) begin n_fail++; $display("FAIL tx_ready_edge_pre: got %h expected %h", d, 32'h0); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL tx_ready_back: got %h expected %h", d, 32'h1); end
    repeat (3) begin
      tick();
      if (tx_start === 1'b1) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_fail++; $display("FAIL tx_drop_nostart: got %0d extra starts expected 0", pulses); end
    n_vec++; if (tx_data !== 8'h3C) begin n_fail++; $display("FAIL tx_drop_data: got %h expected 3c", tx_data); end
    bus_write(A_DATA, 8'h81);
    n_vec++; if (tx_start !== 1'b1 || tx_data !== 8'h81) begin n_fail++; $display("FAIL tx_second: got %b/%h expected 1/81", tx_start, tx_data); end
    tick(); tx_busy = 1'b1;
    tick(); tick(); tx_busy = 1'b0;
    tick(); tick();
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL tx_second_done: got %h expected %h", d, 32'h1); end
    $display("tx: sent 3c and 81, write of 77 while busy dropped");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    push_byte(8'h66);
    bus_ce = 1'b1; bus_we = 1'b0; bus_addr = A_DATA;
    tick();
    bus_ce = 1'b1; bus_we = 1'b1; bus_addr = A_DATA; bus_wdata = 8'h12;
    n_vec++; if (bus_rdata !== 32'h66 || bus_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_read: got %h/%b expected 00000066/1", bus_rdata, bus_rvalid); end
    tick();
    bus_ce = 1'b0; bus_we = 1'b0;
    n_vec++; if (tx_start !== 1'b1 || tx_data !== 8'h12) begin n_fail++; $display("FAIL b2b_write: got %b/%h expected 1/12", tx_start, tx_data); end
    n_vec++; if (bus_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_write_rvalid: got %b expected 0", bus_rvalid); end
    tick(); tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    repeat (3) tick();
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL b2b_stat: got %h expected %h", d, 32'h1); end
    $display("back_to_back: read 66 then write 12 in consecutive cycles");
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d; logic v;
    bus_write(A_DATA, 8'h55);
    tick(); tx_busy = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    tick();
    n_vec++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pre: got %b expected 1", irq); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h2) begin n_fail++; $display("FAIL mid_stat_pre: got %h expected %h", d, 32'h2); end
    rst = 1'b1;
    tick();
    n_vec++; if (read_ce !== 1'b0) begin n_fail++; $display("FAIL mid_read_ce_rst: got %b expected 0", read_ce); end
    tick();
    rst = 1'b0; tx_busy = 1'b0;
    tick();
    n_vec++; if (read_ce !== 1'b1 || irq !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_post: got read_ce=%b irq=%b tx_start=%b expected 1/0/0", read_ce, irq, tx_start); end
    bus_read(A_STAT, d, v);
    n_vec++; if (d !== 32'h1) begin n_fail++; $display("FAIL mid_stat_post: got %h expected %h", d, 32'h1); end
    bus_read(A_DATA, d, v);
    n_vec++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_fifo_cleared: got %h expected %h", d, 32'h0); end
    n_vec++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq_post: got %b expected 0", irq); end
    $display("reset_mid_tx: STAT=%h after reset in WAIT_DONE", 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rx_single();
    test_overflow();
    test_full_push_pop();
    test_empty_read();
    test_tx();
    test_back_to_back();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped UART controller between the CPU data bus and the UART serial engines. It keeps the byte receiver permanently armed, edge-detects its completion flag, and buffers received bytes in a receive FIFO. It accepts CPU writes into a one-byte transmit holding register and sequences the transmitter through a start/busy handshake. It exposes the standard data register (offset 0x0) and status register (offset 0x4) of the SoC UART window.

## Interface
Parameters:
- FIFO_DEPTH, 16: RX FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH): FIFO pointer width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- bus_ce  in  1  access strobe; one cycle per access.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  3  byte offset; only bit 2 is decoded (0 = DATA, 1 = STAT).
- bus_wdata  in  8  write byte.
- bus_rdata  out  32  read data, zero-extended.
- bus_rvalid  out  1  read data valid, one cycle after a read bus_ce.
- read_ce  out  1  receiver enable.
- rx_fin  in  1  receiver completion level; stays high until the next start bit.
- rx_data  in  8  receiver byte; valid while rx_fin is high.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  transmit byte; held stable from tx_start until tx_busy falls.
- tx_busy  in  1  transmitter busy.
- irq  out  1  level interrupt: RX FIFO not empty OR overrun flag set.

## Operation
- read_ce is driven 1 whenever rst is low.
- RX capture:
  - rx_fin passes through a 2-flop synchronizer, then a rising-edge detector.
  - On each rising edge, rx_data is pushed into the FIFO. rx_data is sampled on the cycle the edge is detected.
  - If the FIFO is full, the byte is dropped and the sticky flag ovr is set.
- DATA read pops the FIFO head into bus_rdata[7:0]. Reading DATA while the FIFO is empty returns 0 and does not move the pointers.
- STAT read returns:
  - bit0 = tx_ready (holding register empty).
  - bit1 = rx_avail (FIFO not empty).
  - bit2 = ovr.
  - bit3 = fifo_full.
  - all other bits 0.
  - A STAT read clears ovr after returning it.
- DATA write while tx_ready is set loads the holding register and clears tx_ready. A DATA write while tx_ready is clear is dropped. STAT writes are ignored.
- TX FSM states and transitions:
  - T_IDLE → T_START when the holding register is full.
  - T_START asserts tx_start for exactly one cycle, then → T_WAIT_BUSY.
  - T_WAIT_BUSY → T_WAIT_DONE when tx_busy = 1.
  - T_WAIT_DONE → T_IDLE when tx_busy = 0; tx_ready is set on that same edge.
- FIFO push and pop in the same cycle:
  - Not empty: both take effect and the count is unchanged.
  - Empty: the pop returns 0 and the push succeeds.
  - Full: pop and push both succeed and ovr is not set.
- FIFO pointers are PTR_W+1 bits wide. Full and empty are derived from the MSB and the equality of the pointers. The pointers wrap naturally.

## Timing
- Reset values:
  - bus_rdata = 0, bus_rvalid = 0.
  - tx_start = 0, tx_data = 0.
  - read_ce = 0 while rst is high.
  - irq = 0, ovr = 0, tx_ready = 1.
  - FIFO empty; TX FSM = T_IDLE.
  - The synchronizer and edge-detect flops are cleared to 0.
- Reset asserted mid-transmit returns the FSM to T_IDLE on the next edge. An in-flight transmission is not tracked afterwards.
- Read latency is 1 cycle: bus_rdata and bus_rvalid are registered. bus_rvalid is high for exactly one cycle.
- Push latency: a byte is visible in rx_avail 3 cycles after rx_fin rises (2 synchronizer cycles plus 1 push cycle).
- A DATA write at cycle n produces tx_start at cycle n+1, and tx_ready = 0 from cycle n+1 onward.
- irq is registered and updates one cycle after any FIFO or ovr change.
- A back-to-back read and write in consecutive cycles are each honoured in order.

## Structure
- Package uart_pkg:
  - Offsets ADDR_DATA = 3'h0, ADDR_STAT = 3'h4.
  - Status bit indices STAT_TXRDY = 0, STAT_RXAV = 1, STAT_OVR = 2, STAT_FULL = 3.
  - TX state encoding T_IDLE, T_START, T_WAIT_BUSY, T_WAIT_DONE.
- One sub-module: uart_rx_fifo, a synchronous FIFO parameterized by FIFO_DEPTH with push/pop/full/empty/count.
- The synchronizer, edge detector, register decode and TX FSM live in the top module.

## Test plan
- Pulse rx_fin with rx_data = 8'hA5. Required: STAT = 32'h3 three cycles later; a DATA read gives 32'hA5 with bus_rvalid one cycle later; STAT then reads 32'h1.
- Push 17 bytes 0x00..0x10 with FIFO_DEPTH = 16. Required: STAT reads 32'hF (tx_ready, rx_avail, ovr, full); 16 DATA reads return 0x00..0x0F; a second STAT read shows ovr cleared.
- Write 8'h3C to DATA, model tx_busy high for 10 cycles starting 2 cycles after tx_start. Required: tx_start is a single cycle with tx_data = 8'h3C; tx_ready returns 1 the cycle tx_busy falls; a second write issued before that point is dropped.
- With the FIFO full, push and pop in the same cycle. Required: count stays 16 and ovr stays 0.
- Read DATA with the FIFO empty. Required: bus_rdata = 0 and the pointers are unchanged.
- Assert rst in T_WAIT_DONE with 3 bytes queued. Required: after release, STAT = 32'h1, irq = 0, read_ce = 1.
